// File: rtl/lsu_pkg.sv
// Shared RV32I load/store funct3 encodings, LSU state encoding and legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  function automatic logic f3_legal(input logic ld, input logic [2:0] f3);
    if (ld) return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    return f3 inside {F3_B, F3_H, F3_W};
  endfunction

  // Only meaningful for legal encodings: low two bits give the access size.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte-lane steering: store data replication/strobes and load select/extension.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] ld_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    case (off)
      2'd0:    sel_byte = rdata[7:0];
      2'd1:    sel_byte = rdata[15:8];
      2'd2:    sel_byte = rdata[23:16];
      default: sel_byte = rdata[31:24];
    endcase
    sel_half = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wdata = '0;
    wstrb = '0;
    case (funct3)
      F3_B: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << off;
      end
      F3_H: begin
        wdata = {2{store_data[15:0]}};
        wstrb = 4'b0011 << off;
      end
      F3_W: begin
        wdata = store_data;
        wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = '0;
    case (funct3)
      F3_B:    ld_data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   ld_data = {24'd0, sel_byte};
      F3_H:    ld_data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   ld_data = {16'd0, sel_half};
      F3_W:    ld_data = rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one memory transaction per instruction, stalls the pipe until done.
// Zero-wait access completes two cycles after start; errors complete after one.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_s_instr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state_q;
  logic [7:0]  cnt_q;
  logic        ld_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        go;
  logic [2:0]  lane_f3;
  logic [1:0]  lane_off;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [31:0] lane_ld;

  assign go   = (state_q == ST_IDLE) && start && (is_load || is_s_instr);
  assign busy = go || (state_q == ST_REQ);

  // Lanes see live inputs while accepting, latched fields while the read is in flight.
  assign lane_f3  = (state_q == ST_IDLE) ? funct3 : f3_q;
  assign lane_off = (state_q == ST_IDLE) ? addr[1:0] : off_q;

  lsu_lane u_lane (
    .funct3     (lane_f3),
    .off        (lane_off),
    .store_data (store_data),
    .rdata      (mem_rdata),
    .wdata      (lane_wdata),
    .wstrb      (lane_wstrb),
    .ld_data    (lane_ld)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ld_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      done       <= 1'b0;
      load_data  <= '0;
      misaligned <= 1'b0;
      fault      <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            ld_q  <= is_load;
            f3_q  <= funct3;
            off_q <= addr[1:0];
            if (!f3_legal(is_load, funct3)) begin
              fault     <= 1'b1;
              load_data <= '0;
              done      <= 1'b1;
              state_q   <= ST_DONE;
            end else if (f3_misaligned(funct3, addr[1:0])) begin
              misaligned <= 1'b1;
              load_data  <= '0;
              done       <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              cnt_q     <= '0;
              mem_req   <= 1'b1;
              mem_we    <= !is_load;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= is_load ? 32'd0 : lane_wdata;
              mem_wstrb <= is_load ? 4'd0 : lane_wstrb;
              state_q   <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_ready || cnt_q == 8'(TIMEOUT - 1)) begin
            // A ready in the final timeout cycle still counts as success.
            fault     <= !mem_ready;
            load_data <= (mem_ready && ld_q) ? lane_ld : 32'd0;
            done      <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            state_q   <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          done       <= 1'b0;
          misaligned <= 1'b0;
          fault      <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table for single transactions plus timeout and reset sequences.
module tb_lsu;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_load;
  logic        is_s_instr;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  lsu #(.TIMEOUT(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_load    (is_load),
    .is_s_instr (is_s_instr),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .misaligned (misaligned),
    .fault      (fault),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rd;
    int          wt;
    logic        req;
    logic [31:0] maddr;
    logic [31:0] wdat;
    logic [3:0]  strb;
    logic        we;
    logic        mis;
    logic        flt;
    logic [31:0] ldat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    start      = 1'b1;
    is_load    = v.ld;
    is_s_instr = v.st;
    funct3     = v.f3;
    addr       = v.a;
    store_data = v.sd;
    mem_rdata  = v.rd;
    mem_ready  = 1'b0;
    #1;
    chk({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    if (v.req) begin
      chk({tag, "_req"},   {31'd0, mem_req}, 32'd1);
      chk({tag, "_busy"},  {31'd0, busy}, 32'd1);
      chk({tag, "_addr"},  mem_addr, v.maddr);
      chk({tag, "_wdata"}, mem_wdata, v.wdat);
      chk({tag, "_wstrb"}, {28'd0, mem_wstrb}, {28'd0, v.strb});
      chk({tag, "_we"},    {31'd0, mem_we}, {31'd0, v.we});
      for (int k = 0; k < v.wt; k++) begin
        @(posedge clk); #1;
      end
      chk({tag, "_req_hold"}, {31'd0, mem_req}, 32'd1);
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_no_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mis"}, {31'd0, misaligned}, {31'd0, v.mis});
    chk({tag, "_fault"}, {31'd0, fault}, {31'd0, v.flt});
    chk({tag, "_ldata"}, load_data, v.ldat);
    @(posedge clk); #1;
    chk({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    chk({tag, "_err_clr"}, {30'd0, misaligned, fault}, 32'd0);
    chk({tag, "_ldata_hold"}, load_data, v.ldat);
  endtask

  initial begin
    int n;
    vec_t rv;

    // ld st f3 addr sd rdata wait req maddr wdata strb we mis flt ldata
    vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 1'b1, 32'h104, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 0, 1'b1, 32'h200, 32'hA5A5A5A5, 4'h8, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 3'b001, 32'h302, 32'h1234BEEF, 32'h0, 1, 1'b1, 32'h300, 32'hBEEFBEEF, 4'hC, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h0080FF00, 2, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'hFFFFFF80};
    vecs[4]  = '{1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 32'h0080FF00, 0, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h00000080};
    vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h0080FF00, 0, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h00000080};
    vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h0080FF00, 0, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0000FF00};
    vecs[7]  = '{1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 32'h0080FF00, 0, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'hFFFFFF00};
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 3'b001, 32'h101, 32'h5555, 32'h0, 0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 3'b100, 32'h100, 32'h5555, 32'h0, 0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 1'b1, 3'b000, 32'h001, 32'hFFFF, 32'h00007F00, 0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0000007F};
    vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h008, 32'h0, 32'hCAFEF00D, 1, 1'b1, 32'h8, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D};
    vecs[14] = '{1'b0, 1'b1, 3'b000, 32'h000, 32'h00000011, 32'h0, 0, 1'b1, 32'h0, 32'h11111111, 4'h1, 1'b1, 1'b0, 1'b0, 32'h0};

    reset = 1'b1; start = 1'b0; is_load = 1'b0; is_s_instr = 1'b0;
    funct3 = 3'd0; addr = 32'd0; store_data = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
    #12;
    chk("rst_ctrl", {28'd0, busy, done, misaligned, fault}, 32'd0);
    chk("rst_bus", {27'd0, mem_req, mem_we, mem_wstrb == 4'd0 ? 3'd0 : 3'd1}, 32'd0);
    chk("rst_addr", mem_addr | mem_wdata | load_data, 32'd0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 15; i++) run(vecs[i], i);

    // start with neither load nor store is ignored
    @(negedge clk);
    start = 1'b1; is_load = 1'b0; is_s_instr = 1'b0; funct3 = 3'b010; addr = 32'h40;
    #1;
    chk("ign_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_idle", {30'd0, mem_req, done}, 32'd0);
    @(posedge clk); #1;
    chk("ign_idle2", {30'd0, mem_req, done}, 32'd0);

    // timeout: ready never comes; a start during REQ must be ignored
    @(negedge clk);
    start = 1'b1; is_load = 1'b1; is_s_instr = 1'b0; funct3 = 3'b010; addr = 32'h40; mem_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (mem_req === 1'b1 && n < 200) begin
      n++;
      if (n == 10) begin
        start = 1'b1; addr = 32'h80; funct3 = 3'b000;
      end else begin
        start = 1'b0;
      end
      if (n == 30) chk("to_addr_stable", mem_addr, 32'h40);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("to_req_cycles", n, 32'd64);
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_ldata", load_data, 32'd0);
    @(posedge clk); #1;
    chk("to_after", {29'd0, done, fault, mem_req}, 32'd0);
    chk("to_after_busy", {31'd0, busy}, 32'd0);

    // asynchronous reset during REQ
    @(negedge clk);
    start = 1'b1; is_load = 1'b1; is_s_instr = 1'b0; funct3 = 3'b010; addr = 32'h0; mem_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rr_req", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rr_async", {29'd0, mem_req, busy, done}, 32'd0);
    @(negedge clk); reset = 1'b0;
    rv = '{1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 32'h12345678, 0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h12345678};
    run(rv, 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
